// File: rtl/cache_refill_ctrl.sv
// Refill/write-through controller for a direct-mapped word cache between the MEM stage and data memory.
// Load hits complete in IDLE; misses and stores go through a single req/ack memory transaction.
module cache_refill_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 5,
    parameter int CNT_W   = 32,
    localparam int TAG_W  = ADDR_W - INDEX_W - 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_ren,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] cache_addr,
    output logic              cache_wen,
    output logic [DATA_W-1:0] cache_wdata,
    input  logic              cache_valid,
    input  logic [TAG_W-1:0]  cache_label,
    input  logic [DATA_W-1:0] cache_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  perf_hits,
    output logic [CNT_W-1:0]  perf_misses
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_FILL    = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_DONE = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic                hit_s;
    logic                is_store_s;
    logic                is_load_s;
    logic                stall_s;
    logic                hit_inc_s;
    logic                miss_inc_s;
    logic                latch_rd_s;
    logic                latch_wr_s;
    logic                fill_cap_s;
    logic [DATA_W-1:0]   rdata_s;
    logic                wr_hit_r;
    logic [DATA_W-1:0]   fill_data_r;
    logic                mem_req_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic                cache_wen_r;
    logic [DATA_W-1:0]   cache_wdata_r;
    logic [CNT_W-1:0]    perf_hits_r;
    logic [CNT_W-1:0]    perf_misses_r;

    assign hit_s      = cache_valid & (cache_label == cpu_addr[ADDR_W-1:INDEX_W+2]);
    assign is_store_s = cpu_wen;
    assign is_load_s  = cpu_ren & ~cpu_wen;

    // Next-state decode plus the combinational CPU-side responses.
    always_comb begin
        state_s    = state_r;
        stall_s    = 1'b0;
        hit_inc_s  = 1'b0;
        miss_inc_s = 1'b0;
        latch_rd_s = 1'b0;
        latch_wr_s = 1'b0;
        fill_cap_s = 1'b0;
        rdata_s    = cache_rdata;
        case (state_r)
            ST_IDLE: begin
                if (is_store_s) begin
                    stall_s    = 1'b1;
                    latch_wr_s = 1'b1;
                    state_s    = ST_WR_REQ;
                end else if (is_load_s) begin
                    if (hit_s) begin
                        hit_inc_s = 1'b1;
                    end else begin
                        stall_s    = 1'b1;
                        miss_inc_s = 1'b1;
                        latch_rd_s = 1'b1;
                        state_s    = ST_RD_REQ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                stall_s = 1'b1;
                if (mem_ack) begin
                    fill_cap_s = 1'b1;
                    state_s    = ST_FILL;
                end else begin
                    state_s = ST_RD_REQ;
                end
            end
            ST_FILL: begin
                rdata_s = fill_data_r;
                state_s = ST_IDLE;
            end
            ST_WR_REQ: begin
                stall_s = 1'b1;
                if (mem_ack) begin
                    state_s = ST_WR_DONE;
                end else begin
                    state_s = ST_WR_REQ;
                end
            end
            ST_WR_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Memory/cache strobes are registered from the next state so they come straight off flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= '0;
            mem_wdata_r   <= '0;
            wr_hit_r      <= 1'b0;
            fill_data_r   <= '0;
            cache_wen_r   <= 1'b0;
            cache_wdata_r <= '0;
        end else begin
            mem_req_r   <= (state_s == ST_RD_REQ) | (state_s == ST_WR_REQ);
            mem_we_r    <= (state_s == ST_WR_REQ);
            cache_wen_r <= (state_s == ST_FILL) | ((state_s == ST_WR_DONE) & wr_hit_r);
            if (latch_wr_s) begin
                mem_addr_r    <= cpu_addr;
                mem_wdata_r   <= cpu_wdata;
                wr_hit_r      <= hit_s;
                cache_wdata_r <= cpu_wdata;
            end else if (latch_rd_s) begin
                mem_addr_r <= cpu_addr;
            end else if (fill_cap_s) begin
                fill_data_r   <= mem_rdata;
                cache_wdata_r <= mem_rdata;
            end
        end
    end

    // Wrapping load hit/miss performance counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_hits_r   <= '0;
            perf_misses_r <= '0;
        end else begin
            if (hit_inc_s) begin
                perf_hits_r <= perf_hits_r + CNT_W'(1);
            end
            if (miss_inc_s) begin
                perf_misses_r <= perf_misses_r + CNT_W'(1);
            end
        end
    end

    assign cpu_rdata   = rdata_s;
    assign cpu_stall   = stall_s;
    assign cache_addr  = cpu_addr;
    assign cache_wen   = cache_wen_r;
    assign cache_wdata = cache_wdata_r;
    assign mem_req     = mem_req_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign perf_hits   = perf_hits_r;
    assign perf_misses = perf_misses_r;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl with a behavioural cache array and a programmable-latency memory.
module tb_cache_refill_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_ren, cpu_wen;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic [31:0] cache_addr;
    logic        cache_wen;
    logic [31:0] cache_wdata;
    logic        cache_valid;
    logic [24:0] cache_label;
    logic [31:0] cache_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] perf_hits, perf_misses;

    always #5 clk = ~clk;

    cache_refill_ctrl dut (
        .clk(clk), .resetn(resetn),
        .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .cache_addr(cache_addr), .cache_wen(cache_wen), .cache_wdata(cache_wdata),
        .cache_valid(cache_valid), .cache_label(cache_label), .cache_rdata(cache_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .perf_hits(perf_hits), .perf_misses(perf_misses)
    );

    // Cache storage: not affected by resetn.
    logic        cv [32];
    logic [24:0] ct [32];
    logic [31:0] cd [32];

    always_comb begin
        cache_valid = cv[cache_addr[6:2]];
        cache_label = ct[cache_addr[6:2]];
        cache_rdata = cd[cache_addr[6:2]];
    end

    always @(posedge clk) begin
        if (cache_wen) begin
            cv[cache_addr[6:2]] <= 1'b1;
            ct[cache_addr[6:2]] <= cache_addr[31:7];
            cd[cache_addr[6:2]] <= cache_wdata;
        end
    end

    // Memory: acks after ack_delay req cycles (0 = ack in first req cycle).
    logic [31:0] mem [256];
    int          ack_delay = 0;
    int          req_cnt = 0;

    assign mem_ack   = mem_req && (req_cnt == ack_delay);
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_req && !mem_ack) req_cnt <= req_cnt + 1;
        else                     req_cnt <= 0;
        if (mem_req && mem_ack && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          is_load;
        logic [31:0] rdata;
        int          stalls;
        int          wens;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t q[$];

    // Monitor: checks memory-side strobes while pending and pops one record per completed request.
    int st_cnt = 0;
    int wen_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!resetn) begin
            st_cnt  = 0;
            wen_cnt = 0;
        end else begin
            if (cache_wen) wen_cnt++;
            if (mem_req && q.size() > 0) begin
                chk("mem_we", {31'd0, mem_we}, {31'd0, q[0].we});
                chk("mem_addr", mem_addr, q[0].addr);
                if (q[0].we) chk("mem_wdata", mem_wdata, q[0].wdata);
            end
            if (cpu_ren || cpu_wen) begin
                if (cpu_stall) begin
                    st_cnt++;
                end else begin
                    if (q.size() == 0) begin
                        chk("unexpected_completion", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        if (e.is_load) chk("cpu_rdata", cpu_rdata, e.rdata);
                        chk("stall_cycles", st_cnt, e.stalls);
                        chk("cache_wen_pulses", wen_cnt, e.wens);
                    end
                    st_cnt  = 0;
                    wen_cnt = 0;
                end
            end
        end
    end

    task automatic access(input bit is_store, input logic [31:0] addr, input logic [31:0] wdata,
                          input int delay, input logic [31:0] exp_rdata, input int exp_stalls,
                          input int exp_wens, input logic [31:0] exp_hits, input logic [31:0] exp_misses);
        exp_t e;
        bit   done;
        e.is_load = !is_store;
        e.rdata   = exp_rdata;
        e.stalls  = exp_stalls;
        e.wens    = exp_wens;
        e.we      = is_store;
        e.addr    = addr;
        e.wdata   = wdata;
        q.push_back(e);
        ack_delay = delay;
        cpu_ren   = !is_store;
        cpu_wen   = is_store;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (!cpu_stall) done = 1'b1;
        end
        if (!done) begin
            chk("timeout", 32'd1, 32'd0);
            q.delete();
        end
        @(posedge clk);
        #1;
        cpu_ren = 1'b0;
        cpu_wen = 1'b0;
        chk("perf_hits", perf_hits, exp_hits);
        chk("perf_misses", perf_misses, exp_misses);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 32; i++) begin
            cv[i] = 1'b0; ct[i] = '0; cd[i] = '0;
        end
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
        mem[8'h10] = 32'hDEAD_BEEF;
        mem[8'h30] = 32'hCAFE_F00D;
        mem[8'h80] = 32'h1111_2222;
        resetn = 1'b0; cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_cache_wen", {31'd0, cache_wen}, 32'd0);
        chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_perf_hits", perf_hits, 32'd0);
        chk("rst_perf_misses", perf_misses, 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;

        access(1'b0, 32'h40,  32'h0, 1, 32'hDEAD_BEEF, 3, 1, 32'd0, 32'd1);
        access(1'b0, 32'h40,  32'h0, 0, 32'hDEAD_BEEF, 0, 0, 32'd1, 32'd1);
        access(1'b0, 32'hC0,  32'h0, 0, 32'hCAFE_F00D, 2, 1, 32'd1, 32'd2);
        access(1'b0, 32'h40,  32'h0, 0, 32'hDEAD_BEEF, 2, 1, 32'd1, 32'd3);
        access(1'b1, 32'h40,  32'h1234_5678, 3, 32'h0, 5, 1, 32'd1, 32'd3);
        chk("mem_0x40", mem[8'h10], 32'h1234_5678);
        access(1'b0, 32'h40,  32'h0, 0, 32'h1234_5678, 0, 0, 32'd2, 32'd3);
        access(1'b1, 32'h100, 32'hA5A5_5A5A, 0, 32'h0, 2, 0, 32'd2, 32'd3);
        chk("mem_0x100", mem[8'h40], 32'hA5A5_5A5A);
        access(1'b0, 32'h100, 32'h0, 0, 32'hA5A5_5A5A, 2, 1, 32'd2, 32'd4);

        // Reset in the middle of a read request.
        ack_delay = 20;
        cpu_ren   = 1'b1;
        cpu_addr  = 32'h200;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (mem_req) seen = 1'b1;
        end
        chk("rd_req_seen", {31'd0, seen}, 32'd1);
        #2;
        resetn  = 1'b0;
        cpu_ren = 1'b0;
        #1;
        chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
        chk("abort_cache_wen", {31'd0, cache_wen}, 32'd0);
        chk("abort_perf_hits", perf_hits, 32'd0);
        chk("abort_perf_misses", perf_misses, 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        chk("abort_line_kept", cd[0], 32'hA5A5_5A5A);
        @(posedge clk);
        #1;
        access(1'b0, 32'h40,  32'h0, 0, 32'h1234_5678, 0, 0, 32'd1, 32'd0);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
